banner_sequencer: RTL and testbench

BANNER_SEQUENCER -- requirements
Module: banner_sequencer

---
 rtl/banner_sequencer.sv | 84 ++++++++
 tb/tb_banner_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/banner_sequencer.sv
// banner_sequencer: scrolls a WINDOW_ROWS-row window over a banner ROM, one row per valid/ready handshake
//   clk, rst_n      : clock, synchronous active-low reset
//   enable          : run frames continuously while high
//   rom_address     : banner ROM address (ROM answers one cycle later on rom_data)
//   rom_data        : banner ROM row
//   row_data        : registered row presented downstream
//   row_index       : row position within the frame
//   row_valid       : row_data/row_index valid, held until row_ready
//   row_ready       : downstream accepts the row
//   frame_done      : one-cycle pulse at each frame end
//   offset          : current scroll offset (first ROM row of the window)
//   busy            : sequencer not idle
module banner_sequencer #(
   parameter int ROW_COUNT   = 129,
   parameter int ROW_WIDTH   = 57,
   parameter int WINDOW_ROWS = 16,
   parameter int TICK_DIV    = 1000000,
   localparam int IW = WINDOW_ROWS > 1 ? $clog2(WINDOW_ROWS) : 1,
   localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   output logic [7:0]           rom_address,
   input  logic [ROW_WIDTH-1:0] rom_data,
   output logic [ROW_WIDTH-1:0] row_data,
   output logic [IW-1:0]        row_index,
   output logic                 row_valid,
   input  logic                 row_ready,
   output logic                 frame_done,
   output logic [7:0]           offset,
   output logic                 busy
);
   typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, PRESENT, FRAME_END} state_t;
   state_t state, state_nxt;
   logic [TW-1:0] tick_cnt;
   logic          step_pending;
   logic          tick;
   logic          last_row;
   logic [8:0]    sum;
   assign tick     = tick_cnt == TW'(TICK_DIV - 1);
   assign last_row = row_index == IW'(WINDOW_ROWS - 1);
   assign sum      = {1'b0, offset} + 9'(row_index);
   // Address is only meaningful while the ROM is being read; it is held through CAPTURE.
   assign rom_address = (state == FETCH || state == CAPTURE) ?
                        8'(sum >= 9'(ROW_COUNT) ? sum - 9'(ROW_COUNT) : sum) : '0;
   assign row_valid  = state == PRESENT;
   assign frame_done = state == FRAME_END;
   assign busy       = state != IDLE;
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      state_nxt = enable ? FETCH : IDLE;
         FETCH:     state_nxt = CAPTURE;
         CAPTURE:   state_nxt = PRESENT;
         PRESENT:   state_nxt = !row_ready ? PRESENT : last_row ? FRAME_END : FETCH;
         FRAME_END: state_nxt = enable ? FETCH : IDLE;
         default:   state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tick_cnt     <= '0;
         step_pending <= 1'b0;
         row_data     <= '0;
         row_index    <= '0;
         offset       <= '0;
      end else begin
         tick_cnt     <= tick ? '0 : tick_cnt + 1'b1;
         // A tick landing on the consuming FRAME_END re-arms the step for the next frame.
         step_pending <= tick | (step_pending & (state != FRAME_END));
         if (state == CAPTURE) row_data <= rom_data;
         if (state == PRESENT && row_ready && !last_row) row_index <= row_index + 1'b1;
         if (state == FRAME_END) begin
            row_index <= '0;
            if (step_pending) offset <= offset == 8'(ROW_COUNT - 1) ? '0 : offset + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_banner_sequencer.sv
// tb_banner_sequencer: vector table, directed corner cases and random traffic against a frame-level model
module tb_banner_sequencer;
   localparam int RC = 129, RW = 57, WR = 16, TD = 4;
   logic clk = 0, rst_n = 0, enable = 0, row_ready = 0;
   logic [RW-1:0] rom_data = '0, row_data;
   logic [7:0] rom_address, offset;
   logic [3:0] row_index;
   logic row_valid, frame_done, busy;
   int checks = 0, passes = 0;
   always #5 clk = ~clk;
   banner_sequencer #(.ROW_COUNT(RC), .ROW_WIDTH(RW), .WINDOW_ROWS(WR), .TICK_DIV(TD)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .rom_address(rom_address), .rom_data(rom_data),
      .row_data(row_data), .row_index(row_index), .row_valid(row_valid), .row_ready(row_ready),
      .frame_done(frame_done), .offset(offset), .busy(busy));
   function automatic logic [RW-1:0] rom_val(input int a);
      return RW'(a) * 57'h1_0001_0001 + RW'(7);
   endfunction
   always @(posedge clk) rom_data <= rom_val(int'(rom_address));
   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask
   task automatic cyc(input int k = 1);
      repeat (k) @(posedge clk);
      #1;
   endtask
   // Frame-level reference: rows come out in order offset+i mod RC, a frame ends after WR
   // accepted rows, and each frame end consumes at most one pending scroll step.
   logic was_rst = 0, live = 0;
   always @(posedge clk) begin
      was_rst <= !rst_n;
      live    <= 1'b1;
   end
   int n = 0, exp_off = 0, exp_idx = 0, aligned = 0;
   bit pend = 0, fd_due = 0, fd;
   always @(negedge clk) if (live) begin
      if (was_rst) begin
         n = 0; exp_off = 0; exp_idx = 0; pend = 0; fd_due = 0;
         check("rst_ctl", {row_valid, frame_done, busy, rom_address, offset, row_index}, 0);
         check("rst_data", row_data, 0);
      end
      check("offset", offset, exp_off);
      check("step_pending", dut.step_pending, pend);
      check("frame_done", frame_done, fd_due);
      fd = fd_due;
      fd_due = 0;
      if (row_valid && row_ready) begin
         check("row_index", row_index, exp_idx);
         check("row_data", row_data, rom_val((exp_off + exp_idx) % RC));
         if (exp_idx == WR - 1) begin exp_idx = 0; fd_due = 1; end
         else exp_idx++;
      end
      if (fd && pend) begin
         exp_off = (exp_off + 1) % RC;
         pend = 0;
         if (n % TD == TD - 1) aligned++;
      end
      if (n % TD == TD - 1) pend = 1;
      n++;
   end
   task automatic wait_valid();
      int c = 0;
      while (!row_valid && c < 30) begin cyc(); c++; end
      if (!row_valid) check("wait_valid_timeout", 0, 1);
   endtask
   task automatic wait_fd();
      int c = 0;
      while (!frame_done && c < 400) begin cyc(); c++; end
      check("frame_done_seen", frame_done, 1);
   endtask
   task automatic do_reset();
      rst_n = 0; enable = 0; row_ready = 0;
      cyc(3);
      rst_n = 1;
   endtask
   typedef struct {bit en, rdy, valid, busy; logic [3:0] idx; logic [7:0] addr; logic [RW-1:0] data;} vec_t;
   vec_t tbl[9];
   initial begin
      int c, changes, prev;
      tbl[0] = '{1, 0, 0, 0, 0, 0, 0};
      tbl[1] = '{1, 0, 0, 1, 0, 0, 0};
      tbl[2] = '{1, 0, 0, 1, 0, 0, 0};
      tbl[3] = '{1, 0, 1, 1, 0, 0, rom_val(0)};
      tbl[4] = '{1, 1, 1, 1, 0, 0, rom_val(0)};
      tbl[5] = '{1, 1, 0, 1, 1, 1, rom_val(0)};
      tbl[6] = '{1, 1, 0, 1, 1, 1, rom_val(0)};
      tbl[7] = '{1, 1, 1, 1, 1, 0, rom_val(1)};
      tbl[8] = '{1, 0, 0, 1, 2, 2, rom_val(1)};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         enable = tbl[i].en;
         row_ready = tbl[i].rdy;
         check($sformatf("tbl%0d_valid", i), row_valid, tbl[i].valid);
         check($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
         check($sformatf("tbl%0d_idx", i), row_index, tbl[i].idx);
         check($sformatf("tbl%0d_addr", i), rom_address, tbl[i].addr);
         check($sformatf("tbl%0d_data", i), row_data, tbl[i].data);
         cyc();
      end
      wait_valid();
      for (int i = 0; i < 10; i++) begin
         cyc();
         check("bp_valid", row_valid, 1);
         check("bp_idx", row_index, exp_idx);
         check("bp_data", row_data, rom_val((exp_off + exp_idx) % RC));
      end
      row_ready = 1;
      c = 0;
      do begin cyc(); c++; end while (!row_valid && c < 10);
      check("bp_latency", c, 3);
      wait_fd();
      cyc();
      c = 0;
      while (!(row_valid && row_index == 5) && c < 100) begin cyc(); c++; end
      check("drop_at_row5", row_index, 5);
      enable = 0;
      wait_fd();
      cyc();
      check("drop_idle_busy", busy, 0);
      cyc(3);
      check("drop_stay_idle", {busy, row_valid, frame_done}, 0);
      enable = 1;
      c = 0;
      while (!(row_valid && row_index == 7) && c < 100) begin row_ready = 1; cyc(); c++; end
      row_ready = 0;
      check("rst_at_row7", row_index, 7);
      rst_n = 0;
      cyc();
      check("midrst_ctl", {row_valid, frame_done, busy, rom_address, offset, row_index}, 0);
      check("midrst_data", row_data, 0);
      rst_n = 1; row_ready = 1;
      wait_valid();
      check("restart_idx", row_index, 0);
      check("restart_data", row_data, rom_val(0));
      check("restart_offset", offset, 0);
      do_reset();
      enable = 1; row_ready = 1;
      c = 0;
      while (offset != 120 && c < 8000) begin cyc(); c++; end
      check("reach_offset120", offset, 120);
      c = 0;
      while (!frame_done && c < 100) begin
         if (row_valid && row_index == 8) check("wrap_row8", row_data, rom_val(128));
         if (row_valid && row_index == 9) check("wrap_row9", row_data, rom_val(0));
         if (row_valid && row_index == 15) check("wrap_row15", row_data, rom_val(6));
         cyc(); c++;
      end
      do_reset();
      enable = 1; row_ready = 1;
      changes = 0; prev = 0; c = 0;
      do begin
         cyc(); c++;
         if (offset != 8'(prev)) begin changes++; prev = offset; end
      end while (!(offset == 0 && changes > 0) && c < 8000);
      check("wrap_steps", changes, 129);
      check("aligned_tick_seen", aligned > 0, 1);
      for (int i = 0; i < 3000; i++) begin
         enable = $urandom_range(0, 9) != 0;
         row_ready = $urandom_range(0, 1);
         rst_n = $urandom_range(0, 499) != 0;
         cyc();
      end
      rst_n = 1;
      cyc(2);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
